// File: rtl/segment_chase_decoder_pkg.sv
// Shared constants, types and the segment-to-chase-state mapping used by the
// segment chase decoder (and matching the order used by the chase driver).
package segment_chase_pkg;

    localparam int NUM_SEGMENTS = 7;
    localparam int STATE_W      = 3;

    typedef logic [STATE_W-1:0] chase_state_t;

    // Head tracker: nothing decoded yet, or locked onto a chase state.
    typedef enum logic [0:0] {
        TRK_IDLE   = 1'b0,
        TRK_LOCKED = 1'b1
    } track_state_e;

    // Segment lit at each chase state; segment 6 appears twice (states 2 and 6).
    localparam logic [2:0] SEG_ORDER [8] = '{3'd0, 3'd1, 3'd6, 3'd4,
                                             3'd3, 3'd2, 3'd6, 3'd5};

    // Inverse of SEG_ORDER. Segment 6 is ambiguous and is resolved from the
    // previously decoded state: the upper half of the chase (5..7) maps to 6,
    // everything else (including "no previous state") maps to 2.
    function automatic chase_state_t seg_to_state(
        input logic [2:0]   seg_idx,
        input chase_state_t prev_state,
        input logic         prev_valid
    );
        chase_state_t st;
        st = 3'd0;
        if (seg_idx == 3'd6) begin
            if (prev_valid && (prev_state >= 3'd5)) begin
                st = 3'd6;
            end else begin
                st = 3'd2;
            end
        end else begin
            for (int s = 0; s < 8; s++) begin
                if (SEG_ORDER[s] == seg_idx) begin
                    st = 3'(s);
                end else begin
                    st = st;
                end
            end
        end
        return st;
    endfunction

endpackage

// File: rtl/segment_chase_decoder_if.sv
// Segment-line input and decoded-status bundle of the segment chase decoder.
// master = the side that owns the segment lines and consumes the status,
// slave  = the decoder itself.
interface segment_chase_decoder_if
    import segment_chase_pkg::*;
#(
    parameter int PWM_BITS = 5
);

    logic [NUM_SEGMENTS-1:0]          seg_in;
    logic                             invert;
    logic [NUM_SEGMENTS*PWM_BITS-1:0] level;
    logic                             window_done;
    logic                             head_valid;
    logic [STATE_W-1:0]               head_state;
    logic                             step_strobe;
    logic                             step_dir;
    logic                             step_error;

    modport master (
        output seg_in,
        output invert,
        input  level,
        input  window_done,
        input  head_valid,
        input  head_state,
        input  step_strobe,
        input  step_dir,
        input  step_error
    );

    modport slave (
        input  seg_in,
        input  invert,
        output level,
        output window_done,
        output head_valid,
        output head_state,
        output step_strobe,
        output step_dir,
        output step_error
    );

endinterface

// File: rtl/segment_duty_meter.sv
// Per-segment duty meter: counts high samples over one window and publishes
// the count, saturated to P-1, when the shared window counter wraps.
module segment_duty_meter #(
    parameter int PWM_BITS = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sample,
    input  logic                window_end,
    output logic [PWM_BITS-1:0] level
);

    localparam logic [PWM_BITS:0] LEVEL_MAX = {1'b0, {PWM_BITS{1'b1}}};

    logic [PWM_BITS:0]   acc_r;
    logic [PWM_BITS:0]   sum_s;
    logic [PWM_BITS-1:0] level_r;
    logic [PWM_BITS-1:0] level_next_s;

    // Running sum including this cycle's sample, and its saturated form;
    // a segment that is on for all P cycles sums to P and reads as P-1.
    always_comb begin
        sum_s = acc_r + {{PWM_BITS{1'b0}}, sample};
        if (sum_s >= LEVEL_MAX) begin
            level_next_s = LEVEL_MAX[PWM_BITS-1:0];
        end else begin
            level_next_s = sum_s[PWM_BITS-1:0];
        end
    end

    // Accumulate every cycle; at window end publish the level and restart.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_r   <= '0;
            level_r <= '0;
        end else if (window_end) begin
            acc_r   <= '0;
            level_r <= level_next_s;
        end else begin
            acc_r   <= sum_s;
        end
    end

    assign level = level_r;

endmodule

// File: rtl/segment_chase_decoder.sv
// Receive-side decoder for the 7-segment fading chase: measures each
// segment's PWM duty over a free-running window, picks the brightest head
// segment, maps it to the chase state and classifies each step.
module segment_chase_decoder
    import segment_chase_pkg::*;
#(
    parameter int PWM_BITS = 5,
    parameter int HEAD_MIN = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    segment_chase_decoder_if.slave  bus
);

    localparam logic [PWM_BITS-1:0] WCNT_LAST  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] HEAD_MIN_L = PWM_BITS'(HEAD_MIN);

    // Input synchronisers and measurement samples.
    logic [NUM_SEGMENTS-1:0] seg_meta_r;
    logic [NUM_SEGMENTS-1:0] seg_sync_r;
    logic                    inv_meta_r;
    logic                    inv_sync_r;
    logic [NUM_SEGMENTS-1:0] sample_s;

    // Window timing.
    logic [PWM_BITS-1:0]     wcnt_r;
    logic                    window_end_s;
    logic                    window_done_r;

    // Measured levels and head selection.
    logic [NUM_SEGMENTS*PWM_BITS-1:0] level_s;
    logic [PWM_BITS-1:0]     max_level_s;
    logic [2:0]              max_idx_s;
    logic                    head_found_s;
    chase_state_t            decoded_s;

    // Head tracker and step classification.
    track_state_e            trk_state_r;
    track_state_e            trk_next_s;
    chase_state_t            head_state_r;
    chase_state_t            head_state_next_s;
    chase_state_t            state_plus_s;
    chase_state_t            state_minus_s;
    logic                    head_valid_s;
    logic                    step_strobe_r;
    logic                    step_strobe_next_s;
    logic                    step_dir_r;
    logic                    step_dir_next_s;
    logic                    step_error_r;
    logic                    step_error_next_s;

    // Two-flop synchronisers for the asynchronous segment lines and polarity.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_meta_r <= '0;
            seg_sync_r <= '0;
            inv_meta_r <= 1'b0;
            inv_sync_r <= 1'b0;
        end else begin
            seg_meta_r <= bus.seg_in;
            seg_sync_r <= seg_meta_r;
            inv_meta_r <= bus.invert;
            inv_sync_r <= inv_meta_r;
        end
    end

    assign sample_s = seg_sync_r ^ {NUM_SEGMENTS{inv_sync_r}};

    // Free-running window counter; any P-cycle window sees the full duty of a
    // P-periodic signal, so no alignment to the transmitter is attempted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt_r        <= '0;
            window_done_r <= 1'b0;
        end else begin
            wcnt_r        <= wcnt_r + {{(PWM_BITS-1){1'b0}}, 1'b1};
            window_done_r <= window_end_s;
        end
    end

    assign window_end_s = (wcnt_r == WCNT_LAST);

    for (genvar g = 0; g < NUM_SEGMENTS; g++) begin : g_meter
        segment_duty_meter #(
            .PWM_BITS   (PWM_BITS)
        ) u_meter (
            .clk        (clk),
            .reset_n    (reset_n),
            .sample     (sample_s[g]),
            .window_end (window_end_s),
            .level      (level_s[g*PWM_BITS +: PWM_BITS])
        );
    end

    // Argmax over the published levels; strict compare keeps the lowest
    // index on ties.
    always_comb begin
        max_level_s = '0;
        max_idx_s   = 3'd0;
        for (int i = 0; i < NUM_SEGMENTS; i++) begin
            if (level_s[i*PWM_BITS +: PWM_BITS] > max_level_s) begin
                max_level_s = level_s[i*PWM_BITS +: PWM_BITS];
                max_idx_s   = 3'(i);
            end else begin
                max_level_s = max_level_s;
                max_idx_s   = max_idx_s;
            end
        end
    end

    assign head_found_s = (max_level_s >= HEAD_MIN_L);
    assign head_valid_s = (trk_state_r == TRK_LOCKED);
    assign decoded_s    = seg_to_state(max_idx_s, head_state_r, head_valid_s);

    // Tracker next state: lock on the first head, then report every change
    // of decoded state as a step, flagging jumps that are not +/-1 mod 8.
    always_comb begin
        trk_next_s         = trk_state_r;
        head_state_next_s  = head_state_r;
        step_strobe_next_s = 1'b0;
        step_dir_next_s    = 1'b0;
        step_error_next_s  = 1'b0;
        state_plus_s       = head_state_r + 3'd1;
        state_minus_s      = head_state_r - 3'd1;
        case (trk_state_r)
            TRK_IDLE: begin
                if (window_done_r && head_found_s) begin
                    trk_next_s        = TRK_LOCKED;
                    head_state_next_s = decoded_s;
                end else begin
                    trk_next_s        = TRK_IDLE;
                end
            end
            TRK_LOCKED: begin
                if (window_done_r && head_found_s && (decoded_s != head_state_r)) begin
                    head_state_next_s  = decoded_s;
                    step_strobe_next_s = 1'b1;
                    step_dir_next_s    = (decoded_s == state_plus_s);
                    step_error_next_s  = (decoded_s != state_plus_s) &&
                                         (decoded_s != state_minus_s);
                end else begin
                    trk_next_s         = TRK_LOCKED;
                end
            end
            default: begin
                trk_next_s = TRK_IDLE;
            end
        endcase
    end

    // Tracker state and registered step outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trk_state_r   <= TRK_IDLE;
            head_state_r  <= 3'd0;
            step_strobe_r <= 1'b0;
            step_dir_r    <= 1'b0;
            step_error_r  <= 1'b0;
        end else begin
            trk_state_r   <= trk_next_s;
            head_state_r  <= head_state_next_s;
            step_strobe_r <= step_strobe_next_s;
            step_dir_r    <= step_dir_next_s;
            step_error_r  <= step_error_next_s;
        end
    end

    assign bus.level       = level_s;
    assign bus.window_done = window_done_r;
    assign bus.head_valid  = head_valid_s;
    assign bus.head_state  = head_state_r;
    assign bus.step_strobe = step_strobe_r;
    assign bus.step_dir    = step_dir_r;
    assign bus.step_error  = step_error_r;

endmodule

// File: tb/tb_segment_chase_decoder.sv
// Directed self-checking bench for segment_chase_decoder.
module tb_segment_chase_decoder;
    import segment_chase_pkg::*;

    localparam int PWM_BITS = 5;
    localparam int P        = 32;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    int checks   = 0;
    int failures = 0;

    int duty [7];
    int phase = 7;

    int strobe_cnt = 0;
    int dir1_cnt   = 0;
    int err_cnt    = 0;

    segment_chase_decoder_if #(.PWM_BITS(PWM_BITS)) bus();

    segment_chase_decoder #(
        .PWM_BITS (PWM_BITS),
        .HEAD_MIN (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Step-pulse monitor
    always @(negedge clk) begin
        if (bus.step_strobe === 1'b1) begin
            strobe_cnt++;
            if (bus.step_dir === 1'b1) dir1_cnt++;
        end
        if (bus.step_error === 1'b1) err_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [PWM_BITS-1:0] lvl(input int i);
        return bus.level[i*PWM_BITS +: PWM_BITS];
    endfunction

    // One clock: drive the PWM pattern for this phase at the falling edge.
    task automatic cycle();
        logic [6:0] bits;
        @(negedge clk);
        phase++;
        for (int i = 0; i < 7; i++) begin
            bits[i] = (((phase + 3*i) % P) < duty[i]);
        end
        bus.seg_in = bits;
    endtask

    // Run until window_done is seen (bounded), return cycles taken.
    task automatic wait_wd(input string tag, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (bus.window_done !== 1'b1 && n < 40);
        if (bus.window_done !== 1'b1) begin
            failures++;
            $display("FAIL %s window_done timeout got none within %0d cycles", tag, n);
        end
    endtask

    task automatic clear_counts();
        strobe_cnt = 0;
        dir1_cnt   = 0;
        err_cnt    = 0;
    endtask

    task automatic only_seg(input int s, input int d);
        duty = '{default:0};
        duty[s] = d;
    endtask

    task automatic test_reset();
        int n;
        duty = '{default:0};
        bus.seg_in = 7'd0;
        bus.invert = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.level !== '0 || bus.window_done !== 1'b0 || bus.head_valid !== 1'b0 ||
            bus.head_state !== 3'd0 || bus.step_strobe !== 1'b0 ||
            bus.step_dir !== 1'b0 || bus.step_error !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got level=%h wd=%b hv=%b hs=%0d ss=%b sd=%b se=%b required all 0",
                     bus.level, bus.window_done, bus.head_valid, bus.head_state,
                     bus.step_strobe, bus.step_dir, bus.step_error);
        end
        reset_n = 1'b1;
        clear_counts();
        wait_wd("first_window", n);
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL first_window_latency got=%0d required=32", n);
        end
        wait_wd("window_period", n);
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL window_period got=%0d required=32", n);
        end
        wait_wd("third_window", n);
        cycle();
        checks++;
        if (bus.level !== '0 || bus.head_valid !== 1'b0 || strobe_cnt != 0 || err_cnt != 0) begin
            failures++;
            $display("FAIL idle_windows got level=%h hv=%b strobes=%0d errs=%0d required 0,0,0,0",
                     bus.level, bus.head_valid, strobe_cnt, err_cnt);
        end
    endtask

    task automatic test_pwm_seg1();
        int n;
        only_seg(1, 20);
        wait_wd("pwm_w1", n);
        wait_wd("pwm_w2", n);
        checks++;
        if (lvl(1) !== 5'd20) begin
            failures++;
            $display("FAIL pwm_level1 got=%0d required=20", lvl(1));
        end
        checks++;
        if (lvl(0) !== 5'd0 || lvl(6) !== 5'd0) begin
            failures++;
            $display("FAIL pwm_other_levels got l0=%0d l6=%0d required 0,0", lvl(0), lvl(6));
        end
        cycle();
        cycle();
        checks++;
        if (bus.head_valid !== 1'b1 || bus.head_state !== 3'd1 || strobe_cnt != 0) begin
            failures++;
            $display("FAIL pwm_first_head got hv=%b hs=%0d strobes=%0d required 1,1,0",
                     bus.head_valid, bus.head_state, strobe_cnt);
        end
    endtask

    task automatic test_chase_forward();
        int n;
        int seq [3] = '{1, 6, 4};
        logic [2:0] exp [3] = '{3'd1, 3'd2, 3'd3};
        only_seg(0, 32);
        wait_wd("fwd_seg0_w1", n);
        wait_wd("fwd_seg0_w2", n);
        clear_counts();
        checks++;
        if (lvl(0) !== 5'd31) begin
            failures++;
            $display("FAIL full_on_level got=%0d required=31", lvl(0));
        end
        cycle();
        checks++;
        if (bus.head_state !== 3'd0) begin
            failures++;
            $display("FAIL fwd_state0 got=%0d required=0", bus.head_state);
        end
        for (int k = 0; k < 3; k++) begin
            only_seg(seq[k], 32);
            wait_wd("fwd_w1", n);
            wait_wd("fwd_w2", n);
            cycle();
            checks++;
            if (bus.head_state !== exp[k]) begin
                failures++;
                $display("FAIL fwd_state step=%0d got=%0d required=%0d", k, bus.head_state, exp[k]);
            end
        end
        cycle();
        checks++;
        if (strobe_cnt != 3 || dir1_cnt != 3 || err_cnt != 0) begin
            failures++;
            $display("FAIL fwd_strobes got strobes=%0d inc=%0d errs=%0d required 3,3,0",
                     strobe_cnt, dir1_cnt, err_cnt);
        end
    endtask

    task automatic test_chase_reverse();
        int n;
        int seq [2] = '{6, 2};
        logic [2:0] exp [2] = '{3'd6, 3'd5};
        only_seg(5, 32);
        wait_wd("rev_seg5_w1", n);
        wait_wd("rev_seg5_w2", n);
        clear_counts();
        cycle();
        checks++;
        if (bus.head_state !== 3'd7) begin
            failures++;
            $display("FAIL rev_state7 got=%0d required=7", bus.head_state);
        end
        for (int k = 0; k < 2; k++) begin
            only_seg(seq[k], 32);
            wait_wd("rev_w1", n);
            wait_wd("rev_w2", n);
            cycle();
            checks++;
            if (bus.head_state !== exp[k]) begin
                failures++;
                $display("FAIL rev_state step=%0d got=%0d required=%0d", k, bus.head_state, exp[k]);
            end
        end
        cycle();
        checks++;
        if (strobe_cnt != 2 || dir1_cnt != 0 || err_cnt != 0) begin
            failures++;
            $display("FAIL rev_strobes got strobes=%0d inc=%0d errs=%0d required 2,0,0",
                     strobe_cnt, dir1_cnt, err_cnt);
        end
        duty = '{default:32};
        bus.invert = 1'b1;
        wait_wd("inv_w1", n);
        wait_wd("inv_w2", n);
        cycle();
        checks++;
        if (bus.level !== '0 || bus.head_state !== 3'd5 || bus.head_valid !== 1'b1 || strobe_cnt != 2) begin
            failures++;
            $display("FAIL invert_all_high got level=%h hs=%0d hv=%b strobes=%0d required 0,5,1,2",
                     bus.level, bus.head_state, bus.head_valid, strobe_cnt);
        end
    endtask

    task automatic test_step_error();
        int n;
        bus.invert = 1'b0;
        only_seg(0, 32);
        wait_wd("err_seg0_w1", n);
        wait_wd("err_seg0_w2", n);
        clear_counts();
        cycle();
        checks++;
        if (bus.head_state !== 3'd0) begin
            failures++;
            $display("FAIL err_state0 got=%0d required=0", bus.head_state);
        end
        only_seg(3, 32);
        wait_wd("err_seg3_w1", n);
        cycle();
        checks++;
        if (bus.step_strobe !== 1'b1 || bus.step_error !== 1'b1 || bus.step_dir !== 1'b0 ||
            bus.head_state !== 3'd4) begin
            failures++;
            $display("FAIL jump_0_to_4 got ss=%b se=%b sd=%b hs=%0d required 1,1,0,4",
                     bus.step_strobe, bus.step_error, bus.step_dir, bus.head_state);
        end
        wait_wd("err_seg3_w2", n);
        cycle();
        checks++;
        if (strobe_cnt != 1 || err_cnt != 1) begin
            failures++;
            $display("FAIL jump_pulse_count got strobes=%0d errs=%0d required 1,1", strobe_cnt, err_cnt);
        end
    endtask

    task automatic test_below_head_min();
        int n;
        only_seg(2, 10);
        wait_wd("low_w1", n);
        clear_counts();
        wait_wd("low_w2", n);
        checks++;
        if (lvl(2) !== 5'd10) begin
            failures++;
            $display("FAIL low_level2 got=%0d required=10", lvl(2));
        end
        cycle();
        cycle();
        checks++;
        if (bus.head_state !== 3'd4 || strobe_cnt != 0) begin
            failures++;
            $display("FAIL low_state_hold got hs=%0d strobes=%0d required 4,0", bus.head_state, strobe_cnt);
        end
    endtask

    task automatic test_reset_mid_window();
        int n;
        only_seg(4, 32);
        wait_wd("mid_sync", n);
        repeat (10) cycle();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.level !== '0 || bus.head_valid !== 1'b0 || bus.head_state !== 3'd0 ||
            bus.window_done !== 1'b0 || bus.step_strobe !== 1'b0 || bus.step_error !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_clear got level=%h hv=%b hs=%0d wd=%b ss=%b se=%b required all 0",
                     bus.level, bus.head_valid, bus.head_state, bus.window_done,
                     bus.step_strobe, bus.step_error);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        clear_counts();
        wait_wd("recover_w1", n);
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL recover_first_window got=%0d required=32", n);
        end
        wait_wd("recover_w2", n);
        checks++;
        if (lvl(4) !== 5'd31) begin
            failures++;
            $display("FAIL recover_level4 got=%0d required=31", lvl(4));
        end
        cycle();
        cycle();
        checks++;
        if (bus.head_valid !== 1'b1 || bus.head_state !== 3'd3 || strobe_cnt != 0) begin
            failures++;
            $display("FAIL recover_head got hv=%b hs=%0d strobes=%0d required 1,3,0",
                     bus.head_valid, bus.head_state, strobe_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_pwm_seg1();
        test_chase_forward();
        test_chase_reverse();
        test_step_error();
        test_below_head_min();
        test_reset_mid_window();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/segment_chase_decoder.md
Name: segment_chase_decoder

Overview:
- Receive-side counterpart of the 7-segment fading chase driver.
- Samples the seven PWM-modulated segment lines and measures each segment's duty (brightness) over one PWM period.
- Identifies the brightest "head" segment and maps it back to the 3-bit chase state.
- Reports each step and its direction, for on-chip loopback self-test and for decoding a neighbouring tile's display output.

Parameters:
- PWM_BITS, 5, log2 of PWM period in clocks; measurement window P = 2^PWM_BITS cycles.
- HEAD_MIN, 16, minimum level (inclusive) a segment must reach to count as head.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- seg_in  input  7  raw segment lines, bit i = segment i; asynchronous to clk.
- invert  input  1  1 = lines are active-low (XOR-ed before measurement); quasi-static.
- level  output  7*PWM_BITS  per-segment duty count; segment i at bits [i*PWM_BITS +: PWM_BITS].
- window_done  output  1  one-cycle pulse, level just updated.
- head_valid  output  1  sticky once a head has been decoded; cleared only by reset.
- head_state  output  3  decoded chase state.
- step_strobe  output  1  one-cycle pulse when head_state changes.
- step_dir  output  1  1 = increment (+1 mod 8), 0 = decrement; valid with step_strobe.
- step_error  output  1  one-cycle pulse, state changed by other than ±1 mod 8.

Behaviour:
- Reset values (asynchronous assertion, synchronous release, no other reset path): all outputs 0, all counters and accumulators 0, synchroniser flops 0.
- Input path:
  - seg_in and invert each pass through a 2-flop synchroniser.
  - sample[i] = sync_seg[i] ^ sync_invert.
- Window counter:
  - wcnt, PWM_BITS wide, free-running 0..P-1, wraps to 0.
  - No alignment to the transmitter is needed: the high-cycle count of a P-periodic signal is the same for any P-cycle window.
- Accumulation:
  - acc[i] is PWM_BITS+1 wide and adds sample[i] every cycle.
  - On the edge where wcnt == P-1: level[i] <= min(acc[i] + sample[i], P-1); acc[i] <= 0; window_done <= 1 (else 0).
  - A constantly-on segment therefore reads P-1.
- Head decode:
  - Registered, and happens on the edge after window_done, i.e. it uses the new level values.
  - Head = segment with maximum level. Ties go to the lowest index.
  - If max level < HEAD_MIN: no head; head_state, head_valid and strobes are unchanged.
- Segment-to-state map: seg0→0, seg1→1, seg4→3, seg3→4, seg2→5, seg5→7.
- seg6 is ambiguous:
  - previous head_state in {1,2,3} → 2;
  - previous in {5,6,7} → 6;
  - previous in {0,4}, or head_valid == 0 → 2.
- Step classification, when the decoded state differs from head_state and head_valid == 1:
  - step_strobe = 1;
  - step_dir = (new == head_state+1 mod 8);
  - step_error = 1 if new is neither head_state+1 nor head_state-1 mod 8 (step_dir then 0).
- First decode (head_valid 0→1): head_state loads; no strobe, no error.
- Same state re-decoded: no strobe.
- Latency:
  - seg_in edge → sample: 2 cycles.
  - Window end → level: 1 edge.
  - level → head_state / strobes: 1 further edge.
- invert toggling mid-window corrupts only the current window; it is not flagged.
- Reset mid-window discards partial accumulations. The first valid level follows the first full window after release.

Decomposition:
- Package segment_chase_pkg:
  - constants NUM_SEGMENTS=7 and STATE_W=3;
  - the segment-to-state map and seg6 disambiguation as a function;
  - the segment order table {0,1,6,4,3,2,6,5} shared with the driver.
- Sub-module segment_duty_meter: one accumulator plus saturating level register, instantiated 7 times; wcnt is shared from the top level.
- Top level holds the synchronisers, window counter, max/argmax tree and step FSM.

Test Plan:
- Reset, seg_in=0, invert=0 for 3 windows → all level 0, head_valid 0, no strobes, window_done every 32 cycles.
- seg1 driven 20-high/12-low per 32-cycle period at arbitrary phase, others 0 → level[1]=20 after the second window_done; head_valid=1, head_state=1, no strobe.
- Chase sequence seg0, seg1, seg6, seg4, each full-on for 2 windows → head_state 0,1,2,3; three step_strobe pulses, all with step_dir=1, step_error=0.
- Reverse sequence seg5, seg6, seg2 (full-on) → head_state 7,6,5; step_dir=0. Then all segments held high with invert=1 → all levels 0, state holds.
- seg0 full-on, then seg3 full-on → head_state 0 then 4; step_strobe=1 and step_error=1 in the same cycle.
- seg2 at level 10 only (< HEAD_MIN) → state unchanged. reset_n pulsed low mid-window → outputs clear immediately; recovery after 1 full window.
